// File: rtl/switch_nport.sv
// Address-routed packet switch: one valid/ready input stream fanned out to NUM_PORTS
// independent first-word-fall-through output FIFOs, with per-port enable and drop counter.
module switch_nport #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          vld,
  output logic                          rdy,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             data,
  input  logic [NUM_PORTS-1:0]          port_en,
  output logic [NUM_PORTS-1:0]          out_vld,
  input  logic [NUM_PORTS-1:0]          out_rdy,
  output logic [NUM_PORTS*ADDR_W-1:0]   out_addr,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]              drop_cnt
);

  localparam int unsigned PORT_BITS = $clog2(NUM_PORTS);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W     = ADDR_W + DATA_W;
  localparam logic [PTR_W:0] PtrOne = 1;

  logic [PORT_BITS-1:0] dest;
  logic                 dest_en;
  logic                 accept;
  logic [ENT_W-1:0]     in_entry;

  logic [NUM_PORTS-1:0] full, empty, push, pop;
  logic [PTR_W:0]       wr_ptr_q [NUM_PORTS];
  logic [PTR_W:0]       rd_ptr_q [NUM_PORTS];
  logic [PTR_W:0]       cnt      [NUM_PORTS];
  logic [PTR_W:0]       rd_inc   [NUM_PORTS];
  logic [ENT_W-1:0]     mem_q    [NUM_PORTS][FIFO_DEPTH];
  logic [ENT_W-1:0]     head_q   [NUM_PORTS];
  logic [ENT_W-1:0]     head_d   [NUM_PORTS];
  logic [CNT_W-1:0]     drop_q;

  assign dest     = addr[ADDR_W-1 -: PORT_BITS];
  assign dest_en  = port_en[dest];
  assign in_entry = {addr, data};

  // Disabled destinations are always ready so dropped beats never stall the source.
  assign rdy    = rstn && (!dest_en || !full[dest]);
  assign accept = vld && rdy;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      full[p]   = (wr_ptr_q[p][PTR_W] != rd_ptr_q[p][PTR_W]) &&
                  (wr_ptr_q[p][PTR_W-1:0] == rd_ptr_q[p][PTR_W-1:0]);
      empty[p]  = (wr_ptr_q[p] == rd_ptr_q[p]);
      push[p]   = accept && dest_en && (dest == PORT_BITS'(p));
      pop[p]    = !empty[p] && out_rdy[p];
      cnt[p]    = wr_ptr_q[p] - rd_ptr_q[p];
      rd_inc[p] = rd_ptr_q[p] + PtrOne;
      head_d[p] = head_q[p];
      // The head register tracks the entry that will be at the front after this edge.
      if (empty[p] && push[p]) begin
        head_d[p] = in_entry;
      end else if (pop[p]) begin
        if (cnt[p] == PtrOne) begin
          if (push[p]) head_d[p] = in_entry;
        end else begin
          head_d[p] = mem_q[p][rd_inc[p][PTR_W-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        head_q[p]   <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PtrOne;
        if (pop[p])  rd_ptr_q[p] <= rd_inc[p];
        head_q[p] <= head_d[p];
      end
      if (accept && !dest_en && (drop_q != {CNT_W{1'b1}})) drop_q <= drop_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) mem_q[p][wr_ptr_q[p][PTR_W-1:0]] <= in_entry;
    end
  end

  always_comb begin
    out_addr = '0;
    out_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      out_addr[p*ADDR_W +: ADDR_W] = head_q[p][ENT_W-1 -: ADDR_W];
      out_data[p*DATA_W +: DATA_W] = head_q[p][DATA_W-1:0];
    end
  end

  assign out_vld  = ~empty;
  assign drop_cnt = drop_q;

endmodule
